// File: rtl/prng_pkg.sv
// Shared constants, FSM state type and LFSR step rule for the shared PRNG controller.
package prng_pkg;
    localparam int LFSR_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 31'd25;

    typedef enum logic [1:0] {IDLE, FILL, GRANT} state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_LO]};
    endfunction
endpackage

// File: rtl/prng_lfsr.sv
// 31-bit Fibonacci LFSR with load (zero seed replaced by SEED) and step enable.
// Optional run-length health monitor compiled in with PRNG_HEALTH_EN.
module prng_lfsr
    import prng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED      = SEED_DEFAULT,
    parameter int                RUN_LIMIT = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state,
    output logic              health_err
);
    logic [LFSR_W-1:0] load_eff;

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    assign load_eff = (load_val == '0) ? SEED : load_val;

`ifdef PRNG_HEALTH_EN
    localparam int RW = $clog2(RUN_LIMIT + 1);

    logic [RW-1:0] run_q, run_nxt;
    logic          last_q, err_q;

    assign run_nxt = (run_q != '0 && state[TAP_HI] == last_q) ? run_q + 1'b1 : RW'(1);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= SEED;
            run_q  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (load) begin
            state <= load_eff;
            run_q <= '0;
        end else if (step) begin
            // A run that hit the limit on the previous step forces a reseed now.
            if (run_q == RW'(RUN_LIMIT)) begin
                state <= SEED;
                run_q <= '0;
            end else begin
                state  <= lfsr_step(state);
                run_q  <= run_nxt;
                last_q <= state[TAP_HI];
                if (run_nxt == RW'(RUN_LIMIT))
                    err_q <= 1'b1;
            end
        end
    end

    assign health_err = err_q;
`else
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            state <= SEED;
        else if (load)
            state <= load_eff;
        else if (step)
            state <= lfsr_step(state);
    end

    assign health_err = 1'b0;
`endif
endmodule

// File: rtl/prng_share_ctrl.sv
// Round-robin sharing of one LFSR among NUM_REQ requesters; each grant delivers WORD_W fresh bits.
// Optional LFSR health monitor enabled by defining PRNG_HEALTH_EN.
module prng_share_ctrl #(
    parameter int          NUM_REQ      = 4,
    parameter int          WORD_W       = 8,
    parameter logic [30:0] SEED_DEFAULT = 31'd25,
    parameter int          RUN_LIMIT    = 32
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [WORD_W-1:0]  rnd_data,
    input  logic               seed_load,
    input  logic [30:0]        seed_data,
    output logic               busy,
    output logic               health_err
);
    import prng_pkg::*;

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WORD_W + 1);

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, win_q, pick, idx, ptr_nxt;
    logic [CW-1:0]     cnt_q;
    logic [WORD_W-1:0] rnd_q;
    logic [LFSR_W-1:0] lfsr;
    logic              step, fill_done;

    prng_lfsr #(.SEED(SEED_DEFAULT), .RUN_LIMIT(RUN_LIMIT)) u_lfsr (
        .CLK(CLK), .RSTN(RSTN), .step(step), .load(seed_load),
        .load_val(seed_data), .state(lfsr), .health_err(health_err)
    );

    // Scan downward so the last hit is the one closest at/after the pointer.
    always_comb begin
        pick = ptr_q;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (req[idx])
                pick = idx;
        end
    end

    assign fill_done = (cnt_q == CW'(WORD_W - 1));
    assign ptr_nxt   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (|req) begin
                    win_q <= pick;
                    cnt_q <= '0;
                end
                // A reseed restarts the fill so the word comes only from the new seed.
                FILL:  cnt_q <= seed_load ? '0 : cnt_q + 1'b1;
                GRANT: begin
                    rnd_q <= lfsr[WORD_W-1:0];
                    ptr_q <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = FILL;
            FILL:    if (!seed_load && fill_done) state_d = GRANT;
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // LFSR is frozen through GRANT, so its low bits are the word for that cycle.
    always_comb begin
        gnt       = '0;
        rnd_valid = (state_q == GRANT);
        busy      = (state_q != IDLE);
        step      = (state_q == FILL) && !seed_load;
        rnd_data  = rnd_valid ? lfsr[WORD_W-1:0] : rnd_q;
        if (rnd_valid)
            gnt[win_q] = 1'b1;
    end
endmodule

// File: tb/tb_prng_share_ctrl.sv
// Self-checking bench for prng_share_ctrl against a behavioural LFSR/round-robin model.
module tb_prng_share_ctrl;
    localparam int NR = 4;
    localparam int WW = 8;
    localparam int RL = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic          rnd_valid;
    logic [WW-1:0] rnd_data;
    logic          seed_load = 1'b0;
    logic [30:0]   seed_data = '0;
    logic          busy;
    logic          health_err;

    int          vecs = 0;
    int          errs = 0;
    logic [30:0] m_lfsr;
    int          m_ptr;
    int          m_run;
    bit          m_last;
    bit          m_err;

    prng_share_ctrl #(.NUM_REQ(NR), .WORD_W(WW), .SEED_DEFAULT(31'd25), .RUN_LIMIT(RL)) dut (
        .CLK(CLK), .RSTN(RSTN), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .seed_load(seed_load), .seed_data(seed_data),
        .busy(busy), .health_err(health_err)
    );

    always #5 CLK = ~CLK;

    // Reference: shift left by one, feed back bit30 xor bit27 into bit 0.
    function automatic logic [30:0] f_next(input logic [30:0] v);
        logic [31:0] w;
        w = ({1'b0, v} << 1) | {31'd0, v[30] ^ v[27]};
        return w[30:0];
    endfunction

    task automatic m_step();
`ifdef PRNG_HEALTH_EN
        bit b;
        if (m_run == RL) begin
            m_lfsr = 31'd25;
            m_run  = 0;
        end else begin
            b      = m_lfsr[30];
            m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
            m_last = b;
            m_lfsr = f_next(m_lfsr);
            if (m_run == RL) m_err = 1'b1;
        end
`else
        m_lfsr = f_next(m_lfsr);
`endif
    endtask

    task automatic m_fill(input int n);
        for (int i = 0; i < n; i++) m_step();
    endtask

    task automatic m_load(input logic [30:0] s);
        m_lfsr = (s == 31'd0) ? 31'd25 : s;
        m_run  = 0;
    endtask

    task automatic m_reset();
        m_lfsr = 31'd25; m_ptr = 0; m_run = 0; m_last = 1'b0; m_err = 1'b0;
    endtask

    function automatic int m_pick(input logic [NR-1:0] r);
        int j;
        for (int i = 0; i < NR; i++) begin
            j = (m_ptr + i) % NR;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    task automatic wait_grant(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (gnt !== '0) begin n = k; break; end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; #2;
        m_reset();
        vecs++; if ({gnt, rnd_valid, busy, health_err} !== '0) begin errs++;
            $display("FAIL reset_ctl: got %b want 0", {gnt, rnd_valid, busy, health_err}); end
        vecs++; if (rnd_data !== '0) begin errs++;
            $display("FAIL reset_data: got %h want 00", rnd_data); end
        @(posedge CLK); #1; RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_single();
        int n; logic [WW-1:0] w;
        req = 4'b0001;
        @(posedge CLK); #1;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_fill: got %b want 1", busy); end
        wait_grant(n); n = n + 1;
        req = '0;
        m_fill(WW); m_ptr = 1; w = m_lfsr[WW-1:0];
        vecs++; if (n !== WW + 1) begin errs++; $display("FAIL single_lat: got %0d want %0d", n, WW + 1); end
        vecs++; if (gnt !== 4'b0001 || rnd_valid !== 1'b1) begin errs++;
            $display("FAIL single_gnt: got %b/%b want 0001/1", gnt, rnd_valid); end
        vecs++; if (rnd_data !== w) begin errs++; $display("FAIL single_data: got %h want %h", rnd_data, w); end
        @(posedge CLK); #1;
        vecs++; if (gnt !== '0 || rnd_valid !== 1'b0 || rnd_data !== w) begin errs++;
            $display("FAIL single_hold: got %b/%b/%h want 0000/0/%h", gnt, rnd_valid, rnd_data, w); end
    endtask

    task automatic test_all_req();
        int n, w;
        req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            wait_grant(n);
            w = m_pick(4'b1111); m_fill(WW); m_ptr = (w + 1) % NR;
            vecs++; if (gnt !== 4'(1 << w) || n !== (g == 0 ? WW + 1 : WW + 2)) begin errs++;
                $display("FAIL all_gnt%0d: got %b after %0d want %b after %0d", g, gnt, n,
                         4'(1 << w), (g == 0 ? WW + 1 : WW + 2)); end
            vecs++; if (rnd_data !== m_lfsr[WW-1:0] || health_err !== m_err) begin errs++;
                $display("FAIL all_data%0d: got %h/%b want %h/%b", g, rnd_data, health_err, m_lfsr[WW-1:0], m_err); end
        end
        req = '0;
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        int n, w; logic [NR-1:0] r; bit ld; logic [30:0] s;
        for (int it = 0; it < 12; it++) begin
            r  = NR'($urandom_range(1, 15));
            ld = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
            req = r; seed_load = ld; seed_data = s;
            @(posedge CLK); #1;
            seed_load = 1'b0;
            w = m_pick(r);
            if (ld) m_load(s);
            wait_grant(n);
            req = '0;
            m_fill(WW); m_ptr = (w + 1) % NR;
            vecs++; if (gnt !== 4'(1 << w) || n !== WW) begin errs++;
                $display("FAIL rnd_gnt%0d: got %b after %0d want %b after %0d", it, gnt, n, 4'(1 << w), WW); end
            vecs++; if (rnd_data !== m_lfsr[WW-1:0] || health_err !== m_err) begin errs++;
                $display("FAIL rnd_data%0d: got %h/%b want %h/%b", it, rnd_data, health_err, m_lfsr[WW-1:0], m_err); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_seed_zero();
        int n, w; logic [NR-1:0] r;
        seed_load = 1'b1; seed_data = 31'd0;
        @(posedge CLK); #1;
        seed_load = 1'b0; m_load(31'd0);
        r = NR'($urandom_range(1, 15)); req = r;
        wait_grant(n); req = '0;
        w = m_pick(r); m_fill(WW); m_ptr = (w + 1) % NR;
        vecs++; if (gnt !== 4'(1 << w) || rnd_data !== m_lfsr[WW-1:0]) begin errs++;
            $display("FAIL seed_zero: got %b/%h want %b/%h", gnt, rnd_data, 4'(1 << w), m_lfsr[WW-1:0]); end
        @(posedge CLK); #1;
    endtask

    task automatic test_seed_fill();
        int n, w;
        req = 4'b0100; w = m_pick(4'b0100);
        repeat (4) @(posedge CLK);
        #1; seed_load = 1'b1; seed_data = 31'h1234567;
        @(posedge CLK); #1;
        seed_load = 1'b0;
        m_fill(3); m_load(31'h1234567);
        wait_grant(n); req = '0;
        m_fill(WW); m_ptr = (w + 1) % NR;
        vecs++; if (n !== WW || gnt !== 4'(1 << w)) begin errs++;
            $display("FAIL seed_fill_lat: got %b after %0d want %b after %0d", gnt, n, 4'(1 << w), WW); end
        vecs++; if (rnd_data !== m_lfsr[WW-1:0]) begin errs++;
            $display("FAIL seed_fill_data: got %h want %h", rnd_data, m_lfsr[WW-1:0]); end
        @(posedge CLK); #1;
    endtask

    task automatic test_seed_grant();
        int n, w; logic [30:0] s; logic [WW-1:0] old;
        req = 4'b1000; w = m_pick(4'b1000);
        wait_grant(n);
        m_fill(WW); m_ptr = (w + 1) % NR; old = m_lfsr[WW-1:0];
        s = 31'($urandom) | 31'd1;
        req = '0; seed_load = 1'b1; seed_data = s;
        @(posedge CLK); #1;
        seed_load = 1'b0; m_load(s);
        vecs++; if (rnd_data !== old || rnd_valid !== 1'b0) begin errs++;
            $display("FAIL seed_grant_hold: got %h/%b want %h/0", rnd_data, rnd_valid, old); end
        req = 4'b0001; w = m_pick(4'b0001);
        wait_grant(n); req = '0;
        m_fill(WW); m_ptr = (w + 1) % NR;
        vecs++; if (gnt !== 4'(1 << w) || rnd_data !== m_lfsr[WW-1:0]) begin errs++;
            $display("FAIL seed_grant_next: got %b/%h want %b/%h", gnt, rnd_data, 4'(1 << w), m_lfsr[WW-1:0]); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        req = 4'b0010;
        repeat (4) @(posedge CLK);
        #1; RSTN = 1'b0; #1;
        vecs++; if ({gnt, busy, rnd_valid} !== '0 || rnd_data !== '0) begin errs++;
            $display("FAIL reset_mid: got %b/%h want 0/00", {gnt, busy, rnd_valid}, rnd_data); end
        req = '0;
        @(posedge CLK); #1;
        RSTN = 1'b1; m_reset();
        req = 4'b0010;
        wait_grant(n); req = '0;
        m_fill(WW); m_ptr = 2;
        vecs++; if (n !== WW + 1 || gnt !== 4'b0010 || rnd_data !== m_lfsr[WW-1:0]) begin errs++;
            $display("FAIL reset_regrant: got %b/%h after %0d want 0010/%h after %0d",
                     gnt, rnd_data, n, m_lfsr[WW-1:0], WW + 1); end
        @(posedge CLK); #1;
    endtask

`ifdef PRNG_HEALTH_EN
    task automatic test_health();
        int n;
        RSTN = 1'b0; #1; RSTN = 1'b1; m_reset();
        req = 4'b0001; seed_load = 1'b1; seed_data = 31'h7FFFFFFF;
        @(posedge CLK); #1;
        seed_load = 1'b0; m_load(31'h7FFFFFFF);
        repeat (3) @(posedge CLK);
        #1; m_fill(3);
        vecs++; if (health_err !== 1'b0) begin errs++; $display("FAIL health_early: got %b want 0", health_err); end
        @(posedge CLK); #1; m_fill(1);
        vecs++; if (health_err !== 1'b1) begin errs++; $display("FAIL health_set: got %b want 1", health_err); end
        wait_grant(n); req = '0;
        m_fill(4); m_ptr = 1;
        vecs++; if (n !== 4 || rnd_data !== m_lfsr[WW-1:0] || health_err !== 1'b1) begin errs++;
            $display("FAIL health_reload: got %h/%b after %0d want %h/1 after 4", rnd_data, health_err, n, m_lfsr[WW-1:0]); end
        @(posedge CLK); #1;
        seed_load = 1'b1; seed_data = 31'h0ABCDEF;
        @(posedge CLK); #1; seed_load = 1'b0;
        vecs++; if (health_err !== 1'b1) begin errs++; $display("FAIL health_sticky: got %b want 1", health_err); end
        RSTN = 1'b0; #1;
        vecs++; if (health_err !== 1'b0) begin errs++; $display("FAIL health_clear: got %b want 0", health_err); end
        @(posedge CLK); #1; RSTN = 1'b1; m_reset();
        @(posedge CLK); #1;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_all_req();
        test_random();
        test_seed_zero();
        test_seed_fill();
        test_seed_grant();
        test_reset_mid();
`ifdef PRNG_HEALTH_EN
        test_health();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/prng_share_ctrl.md
Name: prng_share_ctrl

Overview:
- Shares one 31-bit Fibonacci LFSR pseudo-random source among NUM_REQ requesters using round-robin arbitration.
- For each granted request, the LFSR is clocked WORD_W times so every requester receives fresh, non-overlapping bits.
- Sits between the common random source and game/LED-pattern blocks that each need random words.
- Also owns reseeding of the source.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_W, 8, random word width delivered per grant (1..31).
- SEED_DEFAULT, 31'd25, LFSR value after reset and substitute for an all-zero seed.
- RUN_LIMIT, 32, identical-bit run length that trips the health check (optional feature only).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; hold high until gnt.
- gnt  out  NUM_REQ  one-hot, single-cycle grant pulse.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- rnd_data  out  WORD_W  random word; valid with rnd_valid and held until the next grant.
- seed_load  in  1  single-cycle reseed strobe.
- seed_data  in  31  new LFSR value, sampled with seed_load.
- busy  out  1  high in FILL and GRANT.
- health_err  out  1  sticky health fault (tied 0 unless PRNG_HEALTH_EN is defined).

Behaviour:
- Reset (RSTN low, asynchronous):
  - gnt=0, rnd_valid=0, rnd_data=0, busy=0, health_err=0.
  - LFSR=SEED_DEFAULT, round-robin pointer=0, state=IDLE, fill count=0.
- LFSR step: next = {lfsr[29:0], lfsr[30]^lfsr[27]}. It advances only in FILL; it never free-runs.
- FSM states and transitions:
  - IDLE: if any req bit is high, pick the first set bit at or after the pointer, scanning upward with wrap. Register the winner, clear the fill count, go to FILL.
  - FILL: step the LFSR once per cycle. After exactly WORD_W steps go to GRANT.
  - GRANT: gnt[winner]=1 and rnd_valid=1 for one cycle. rnd_data<=lfsr[WORD_W-1:0], registered on entry so it is valid in this cycle. Pointer<=winner+1, wrapping at NUM_REQ. Then return to IDLE.
- Latency: a req high at an IDLE edge gives a gnt pulse WORD_W+1 cycles later. Throughput is one word per WORD_W+2 cycles.
- Back-to-back requests:
  - A requester drops req in the cycle after its gnt.
  - If req is still high in IDLE, it is treated as a new request, with lowest priority under round-robin.
- req dropped mid-FILL: the transaction still completes and gnt is issued. Withdrawal is not supported; the requester ignores the pulse.
- seed_load:
  - In IDLE: LFSR<=seed_data, or SEED_DEFAULT if seed_data==0.
  - In FILL: the load takes priority over the step and the fill count restarts at 0, so the delivered word derives entirely from the new seed.
  - In GRANT: the load is applied. rnd_data still takes the pre-load LFSR value.
  - seed_load in IDLE with a request pending: the seed loads this cycle and arbitration proceeds normally.
- All-requesters case: each of NUM_REQ continuously asserted requesters is granted once per NUM_REQ grants, in pointer order.
- rnd_data holds its value between grants. gnt is never multi-hot.

Optional Feature:
- PRNG_HEALTH_EN defined:
  - A run counter tracks consecutive identical LFSR output bits (lfsr[30]) during FILL.
  - When the run reaches RUN_LIMIT, the LFSR is forced to SEED_DEFAULT on the next FILL step and health_err sets.
  - health_err is sticky until RSTN. A seed_load clears the run counter but not health_err.
- PRNG_HEALTH_EN not defined: no run counter, and health_err is a constant 0.

Decomposition:
- Package prng_pkg:
  - constants LFSR_W=31, TAP_HI=30, TAP_LO=27, SEED_DEFAULT;
  - state enum {IDLE, FILL, GRANT}.
- Sub-module prng_lfsr:
  - inputs: CLK, RSTN, step, load, load_val;
  - output: state[30:0];
  - contains the zero-seed substitution and the optional health counter.
- Arbitration and FSM stay in prng_share_ctrl.

Test Plan:
- Reset, then req=4'b0001 (WORD_W=8, default seed 25) -> gnt=4'b0001 exactly 9 cycles later for one cycle, rnd_valid=1, rnd_data equals the reference-model LFSR stepped 8 times from 25, low 8 bits.
- req=4'b1111 held for 8 grants -> gnt order 0,1,2,3,0,1,2,3; no multi-hot gnt; 10-cycle spacing between pulses.
- seed_load with seed_data=0 in IDLE, then one request -> word matches the model seeded from 25; LFSR never reaches the all-zero state.
- seed_load with seed_data=31'h1234567 at the 4th FILL cycle -> gnt delayed to 8 cycles after the load; rnd_data equals the model stepped 8 times from 31'h1234567.
- RSTN pulled low mid-FILL with req=4'b0010 -> gnt, busy and rnd_valid drop to 0 immediately; after release, the first grant again yields the seed-25 word.
- PRNG_HEALTH_EN defined, seed forced to 31'h7FFFFFFF with RUN_LIMIT=4 -> health_err=1 after the 4th identical bit; the LFSR reloads 25; health_err stays set until RSTN.
